seq_adder: RTL and testbench
============================

SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per cycle; WIDTH SHALL be a positive multiple of CHUNK, otherwise elaboration fails.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port valid_i, input, 1: upstream operands valid.
REQ-006 SHALL have port ready_o, output, 1: block can accept operands.
REQ-007 SHALL have port a_i, input, WIDTH: operand A.
REQ-008 SHALL have port b_i, input, WIDTH: operand B.
REQ-009 SHALL have port carry_i, input, 1: carry-in; used in add mode only.
REQ-010 SHALL have port sub_i, input, 1: 0 = add, 1 = subtract.
REQ-011 SHALL have port valid_o, output, 1: result valid.
REQ-012 SHALL have port ready_i, input, 1: downstream accepts result.
REQ-013 SHALL have port sum_o, output, WIDTH: result.
REQ-014 SHALL have port carry_o, output, 1: carry-out of MSB.
REQ-015 SHALL have port overflow_o, output, 1: two's-complement signed overflow.

Function
REQ-016 SHALL define N = WIDTH/CHUNK and implement FSM states IDLE, BUSY, DONE.
REQ-017 SHALL assert ready_o only in IDLE; valid_o only in DONE.
REQ-018 SHALL capture on an accept (IDLE and valid_i and ready_o) a_i, the effective B, and the effective carry-in into internal registers, then enter BUSY with chunk index k = 0.
- Add mode: effective B = b_i, carry-in = carry_i.
- Subtract mode: effective B = ~b_i, carry-in = 1 (carry_i ignored).
REQ-019 SHALL in BUSY add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of A, B and the stored carry in one cycle, write the chunk into the sum register, update the stored carry, and increment k.
REQ-020 SHALL enter DONE on the cycle after chunk N-1 is processed; the accept-to-valid_o latency is exactly N+1 cycles.
REQ-021 SHALL drive in DONE: sum_o = (A + Beff + cin) mod 2^WIDTH; carry_o = bit WIDTH of that sum; overflow_o = (A[MSB] == Beff[MSB]) and (sum_o[MSB] != A[MSB]).
REQ-022 SHALL hold sum_o, carry_o and overflow_o stable while valid_o=1 and ready_i=0 (backpressure, any duration).
REQ-023 SHALL return to IDLE on the cycle after valid_o and ready_i are both 1; the next accept is possible one cycle later.
REQ-024 SHALL ignore valid_i, a_i, b_i, carry_i and sub_i while in BUSY or DONE; captured operands SHALL NOT change mid-operation.
REQ-025 SHALL treat CHUNK == WIDTH (N = 1) as legal: one BUSY cycle, latency 2.
REQ-026 SHALL ignore ready_i in IDLE and BUSY; it has no effect on state.
REQ-027 SHALL drive sum_o, carry_o and overflow_o to 0 outside DONE.

Reset
REQ-028 SHALL, on a rising clk_i edge with rst_ni=0, enter IDLE, clear k, the sum, the carry and all operand registers, and drive ready_o=1 (from the following cycle), valid_o=0, sum_o=0, carry_o=0, overflow_o=0.
REQ-029 SHALL let reset win over any handshake in the same cycle, including asserting reset mid-BUSY or in DONE: the operation is discarded and no valid_o pulse is produced.

Verification
REQ-030 SHALL pass this case: WIDTH=32, CHUNK=4, add, A=0xFFFFFFFF, B=0x00000001, carry_i=0 -> after 9 cycles valid_o=1, sum_o=0x00000000, carry_o=1, overflow_o=0.
REQ-031 SHALL pass this case: subtract, A=0x80000000, B=0x00000001 -> sum_o=0x7FFFFFFF, carry_o=1, overflow_o=1.
REQ-032 SHALL pass this case: add, A=0x7FFFFFFF, B=0, carry_i=1 -> sum_o=0x80000000, carry_o=0, overflow_o=1; with ready_i held 0 for 5 cycles, outputs stable and ready_o=0 throughout.
REQ-033 SHALL pass this case: rst_ni=0 asserted in BUSY cycle 3 -> next cycle ready_o=1, valid_o=0, sum_o=0; no result is ever produced for that operation.
REQ-034 SHALL pass this case: valid_i toggled with new operands during BUSY -> result matches the first accepted operands only.
REQ-035 SHALL pass this case: back-to-back operations with ready_i=1 and CHUNK=32 (N=1) -> one result every 3 cycles, and 1000 random operands in each mode match a reference model.

Source files
------------

// File: rtl/seq_adder.sv
// seq_adder: multi-cycle ripple adder/subtractor that adds CHUNK bits per cycle.
//
// Operands are captured on accept. The block then spends N = WIDTH/CHUNK cycles
// in BUSY, one chunk per cycle from the LSB up. After that it presents the
// result in DONE until the result is taken.
//
// Ports
//   clk_i       clock; all state changes on the rising edge
//   rst_ni      synchronous active-low reset
//   valid_i     upstream operands valid
//   ready_o     block can accept operands (IDLE only)
//   a_i, b_i    operands, WIDTH bits
//   carry_i     carry-in, add mode only
//   sub_i       0 = add, 1 = subtract (A + ~B + 1)
//   valid_o     result valid (DONE only)
//   ready_i     downstream accepts result
//   sum_o       result, WIDTH bits, 0 outside DONE
//   carry_o     carry-out of the MSB, 0 outside DONE
//   overflow_o  two's-complement signed overflow, 0 outside DONE
//   dbg_state_o current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// ready_o does not depend on valid_i, and valid_o does not depend on ready_i.
// While valid_o=1 and ready_i=0, the result outputs hold steady.
// Inputs are ignored outside IDLE.

module seq_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic [1:0]       dbg_state_o
);

  localparam int N  = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  if (CHUNK <= 0 || WIDTH <= 0 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_adder: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // effective B (already inverted for subtract)
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;  // running carry between chunks, final carry-out in DONE

  logic             accept;
  logic [IW-1:0]    base;
  logic [CHUNK:0]   chunk_sum;

  assign accept = (state_q == IDLE) && valid_i;

  // Bit offset of the chunk processed this cycle. k*CHUNK is always below WIDTH,
  // so truncating to IW bits is safe.
  assign base = IW'(32'(k_q) * 32'(CHUNK));

  assign chunk_sum = {1'b0, a_q[base +: CHUNK]}
                   + {1'b0, b_q[base +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry_q};

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (valid_i) state_d = BUSY;
      BUSY:    if (k_q == K_LAST) state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      k_q     <= '0;
      a_q     <= a_i;
      b_q     <= sub_i ? ~b_i : b_i;
      carry_q <= sub_i | carry_i;
      sum_q   <= '0;
    end else if (state_q == BUSY) begin
      sum_q[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
      carry_q              <= chunk_sum[CHUNK];
      k_q                  <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign valid_o     = (state_q == DONE);
  assign sum_o       = valid_o ? sum_q : '0;
  assign carry_o     = valid_o & carry_q;
  // Signed overflow: both addends have the same sign and the result's sign differs.
  assign overflow_o  = valid_o & (a_q[WIDTH-1] == b_q[WIDTH-1])
                               & (sum_q[WIDTH-1] != a_q[WIDTH-1]);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_adder.sv
module tb_seq_adder;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Main DUT: WIDTH=32, CHUNK=4 (N=8)
  logic        valid_i, ready_o, carry_i, sub_i, valid_o, ready_i, carry_o, ovf_o;
  logic [31:0] a_i, b_i, sum_o;
  logic [1:0]  dbg_state;

  // Second DUT: WIDTH=32, CHUNK=32 (N=1)
  logic        valid_i1, ready_o1, carry_i1, sub_i1, valid_o1, ready_i1, carry_o1, ovf_o1;
  logic [31:0] a_i1, b_i1, sum_o1;
  logic [1:0]  dbg_state1;

  seq_adder #(.WIDTH(32), .CHUNK(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .carry_i(carry_i), .sub_i(sub_i),
    .valid_o(valid_o), .ready_i(ready_i), .sum_o(sum_o),
    .carry_o(carry_o), .overflow_o(ovf_o), .dbg_state_o(dbg_state)
  );

  seq_adder #(.WIDTH(32), .CHUNK(32)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i1), .ready_o(ready_o1),
    .a_i(a_i1), .b_i(b_i1), .carry_i(carry_i1), .sub_i(sub_i1),
    .valid_o(valid_o1), .ready_i(ready_i1), .sum_o(sum_o1),
    .carry_o(carry_o1), .overflow_o(ovf_o1), .dbg_state_o(dbg_state1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [33:0] exp_q[$];  // {carry, overflow, sum}

  // Driver: present operands for one cycle while in IDLE, then scramble the inputs.
  // On return, the bench is at the negedge of BUSY cycle 1.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s);
    @(negedge clk);
    valid_i = 1'b1; a_i = a; b_i = b; carry_i = c; sub_i = s;
    @(negedge clk);
    valid_i = 1'b0; a_i = $urandom; b_i = $urandom; carry_i = ~c; sub_i = ~s;
  endtask

  // Bounded wait for valid_o; cyc counts cycles since the accept cycle.
  task automatic wait_valid(input int start, output int cyc);
    cyc = start;
    while (valid_o !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b exp 1", ready_o); else n_pass++;
    n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b exp 0", valid_o); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (ready_o !== 1'b1) $display("FAIL post_reset_ready: got %b exp 1", ready_o); else n_pass++;
    n_checks++;
    if ({valid_o, sum_o, carry_o, ovf_o} !== 35'd0)
      $display("FAIL post_reset_outs: got v=%b s=%h c=%b o=%b exp all 0", valid_o, sum_o, carry_o, ovf_o);
    else n_pass++;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL post_reset_state: got %0d exp 0", dbg_state); else n_pass++;
    n_checks++; if (ready_o1 !== 1'b1) $display("FAIL post_reset_ready1: got %b exp 1", ready_o1); else n_pass++;
  endtask

  task automatic test_vectors();
    logic [31:0] va[8], vb[8], vs[8];
    logic        vc[8], vsub[8], ec[8], ev[8];
    int cyc;
    va[0]=32'hFFFFFFFF; vb[0]=32'h00000001; vc[0]=0; vsub[0]=0; vs[0]=32'h00000000; ec[0]=1; ev[0]=0;
    va[1]=32'h80000000; vb[1]=32'h00000001; vc[1]=0; vsub[1]=1; vs[1]=32'h7FFFFFFF; ec[1]=1; ev[1]=1;
    va[2]=32'h12345678; vb[2]=32'h11111111; vc[2]=1; vsub[2]=0; vs[2]=32'h2345678A; ec[2]=0; ev[2]=0;
    va[3]=32'h00000005; vb[3]=32'h00000007; vc[3]=1; vsub[3]=1; vs[3]=32'hFFFFFFFE; ec[3]=0; ev[3]=0;
    va[4]=32'hDEADBEEF; vb[4]=32'hDEADBEEF; vc[4]=0; vsub[4]=1; vs[4]=32'h00000000; ec[4]=1; ev[4]=0;
    va[5]=32'h80000000; vb[5]=32'h80000000; vc[5]=0; vsub[5]=0; vs[5]=32'h00000000; ec[5]=1; ev[5]=1;
    va[6]=32'h0F0F0F0F; vb[6]=32'hF0F0F0F0; vc[6]=1; vsub[6]=0; vs[6]=32'h00000000; ec[6]=1; ev[6]=0;
    va[7]=32'h7FFFFFFF; vb[7]=32'hFFFFFFFF; vc[7]=0; vsub[7]=1; vs[7]=32'h80000000; ec[7]=0; ev[7]=1;
    for (int i = 0; i < 8; i++) begin
      start_op(va[i], vb[i], vc[i], vsub[i]);
      wait_valid(1, cyc);
      n_checks++; if (cyc !== 9) $display("FAIL vec%0d latency: got %0d exp 9", i, cyc); else n_pass++;
      n_checks++; if (sum_o !== vs[i]) $display("FAIL vec%0d sum: got %h exp %h", i, sum_o, vs[i]); else n_pass++;
      n_checks++; if (carry_o !== ec[i]) $display("FAIL vec%0d carry: got %b exp %b", i, carry_o, ec[i]); else n_pass++;
      n_checks++; if (ovf_o !== ev[i]) $display("FAIL vec%0d overflow: got %b exp %b", i, ovf_o, ev[i]); else n_pass++;
      n_checks++; if (ready_o !== 1'b0) $display("FAIL vec%0d ready_in_done: got %b exp 0", i, ready_o); else n_pass++;
      ready_i = 1'b1;
      @(negedge clk);
      ready_i = 1'b0;
      n_checks++;
      if ({ready_o, valid_o, sum_o} !== {2'b10, 32'h0})
        $display("FAIL vec%0d back_to_idle: got r=%b v=%b s=%h exp r=1 v=0 s=0", i, ready_o, valid_o, sum_o);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    start_op(32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0);
    wait_valid(1, cyc);
    n_checks++; if (cyc !== 9) $display("FAIL bp_latency: got %0d exp 9", cyc); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({valid_o, ready_o, sum_o, carry_o, ovf_o} !== {2'b10, 32'h80000000, 1'b0, 1'b1})
        $display("FAIL bp_hold%0d: got v=%b r=%b s=%h c=%b o=%b exp v=1 r=0 s=80000000 c=0 o=1",
                 i, valid_o, ready_o, sum_o, carry_o, ovf_o);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++; if (valid_o !== 1'b1) $display("FAIL bp_still_valid: got %b exp 1", valid_o); else n_pass++;
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    n_checks++;
    if ({ready_o, valid_o} !== 2'b10) $display("FAIL bp_release: got r=%b v=%b exp r=1 v=0", ready_o, valid_o);
    else n_pass++;
  endtask

  task automatic test_reset_busy();
    int seen;
    start_op(32'h00000010, 32'h00000020, 1'b0, 1'b0);
    repeat (2) @(negedge clk);  // now in BUSY cycle 3
    n_checks++; if (dbg_state !== 2'd1) $display("FAIL rb_in_busy: got %0d exp 1", dbg_state); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if ({ready_o, valid_o, sum_o, dbg_state} !== {2'b10, 32'h0, 2'd0})
      $display("FAIL rb_after: got r=%b v=%b s=%h st=%0d exp r=1 v=0 s=0 st=0", ready_o, valid_o, sum_o, dbg_state);
    else n_pass++;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (valid_o === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL rb_no_result: got %0d valid cycles exp 0", seen); else n_pass++;
  endtask

  task automatic test_reset_done();
    int cyc, seen;
    start_op(32'h00000003, 32'h00000004, 1'b0, 1'b0);
    wait_valid(1, cyc);
    n_checks++; if (sum_o !== 32'h7) $display("FAIL rd_sum: got %h exp 00000007", sum_o); else n_pass++;
    ready_i = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ready_i = 1'b0;
    n_checks++;
    if ({ready_o, valid_o, sum_o, carry_o, ovf_o} !== {2'b10, 34'h0})
      $display("FAIL rd_after: got r=%b v=%b s=%h exp r=1 v=0 s=0", ready_o, valid_o, sum_o);
    else n_pass++;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid_o === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL rd_no_result: got %0d valid cycles exp 0", seen); else n_pass++;
  endtask

  task automatic test_ignore_busy();
    int cyc, bad_ready;
    start_op(32'h00000001, 32'h00000002, 1'b0, 1'b0);
    bad_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (ready_o !== 1'b0) bad_ready++;
      valid_i = 1'b1; a_i = $urandom; b_i = $urandom;
      carry_i = 1'($urandom_range(0, 1)); sub_i = 1'($urandom_range(0, 1));
      ready_i = 1'b1;
      @(negedge clk);
    end
    valid_i = 1'b0; ready_i = 1'b0;
    n_checks++; if (bad_ready !== 0) $display("FAIL ib_ready_busy: got %0d high cycles exp 0", bad_ready); else n_pass++;
    wait_valid(5, cyc);
    n_checks++; if (cyc !== 9) $display("FAIL ib_latency: got %0d exp 9", cyc); else n_pass++;
    n_checks++;
    if ({sum_o, carry_o, ovf_o} !== {32'h3, 2'b00})
      $display("FAIL ib_result: got s=%h c=%b o=%b exp s=00000003 c=0 o=0", sum_o, carry_o, ovf_o);
    else n_pass++;
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    n_checks++; if (ready_o !== 1'b1) $display("FAIL ib_idle: got %b exp 1", ready_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int issued, got, cyc, last;
    logic [31:0] a, b, s;
    logic        c, sb, co, ov;
    longint      ua, ub, ru, sa, sbs, rs;
    logic [33:0] e;
    issued = 0; got = 0; cyc = 0; last = -1;
    ready_i1 = 1'b1;
    while (got < 2000 && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      if (valid_o1 === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL b2b_unexpected: got result %h with empty queue", sum_o1);
        end else begin
          e = exp_q.pop_front();
          if ({carry_o1, ovf_o1, sum_o1} !== e)
            $display("FAIL b2b_result%0d: got c=%b o=%b s=%h exp c=%b o=%b s=%h",
                     got, carry_o1, ovf_o1, sum_o1, e[33], e[32], e[31:0]);
          else n_pass++;
        end
        if (last >= 0) begin
          n_checks++;
          if (cyc - last !== 3) $display("FAIL b2b_gap%0d: got %0d exp 3", got, cyc - last);
          else n_pass++;
        end
        last = cyc;
        got++;
      end
      if (ready_o1 === 1'b1 && issued < 2000) begin
        a  = $urandom;
        b  = $urandom;
        c  = 1'($urandom_range(0, 1));
        sb = (issued >= 1000);
        ua = {32'h0, a};
        ub = {32'h0, b};
        sa = $signed(a);
        sbs = $signed(b);
        if (sb) begin
          s  = a - b;
          co = (a >= b);
          rs = sa - sbs;
        end else begin
          ru = ua + ub + longint'(c);
          s  = ru[31:0];
          co = ru[32];
          rs = sa + sbs + longint'(c);
        end
        ov = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);
        exp_q.push_back({co, ov, s});
        valid_i1 = 1'b1; a_i1 = a; b_i1 = b; carry_i1 = c; sub_i1 = sb;
        issued++;
      end else begin
        valid_i1 = 1'b0;
      end
    end
    valid_i1 = 1'b0;
    n_checks++; if (got !== 2000) $display("FAIL b2b_count: got %0d results exp 2000", got); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL b2b_leftover: got %0d pending exp 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    valid_i = 1'b0; a_i = '0; b_i = '0; carry_i = 1'b0; sub_i = 1'b0; ready_i = 1'b0;
    valid_i1 = 1'b0; a_i1 = '0; b_i1 = '0; carry_i1 = 1'b0; sub_i1 = 1'b0; ready_i1 = 1'b0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_busy();
    test_reset_done();
    test_ignore_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
